kb_ctrl: RTL and testbench
==========================

# kb_ctrl

Keyboard controller between the PS/2 scan-code receiver and the CPU bus. Takes each validated scan byte (one-cycle `ready` strobe plus `data`), folds E0/F0 prefixes into single key events, queues events in a small FIFO, and exposes them to software through a three-register bus slave with an optional interrupt line.

## Interface
- `DEPTH`, default 8: FIFO entries, power of two, 2..64.
- `AW`, default log2(`DEPTH`): FIFO pointer width, derived and not overridden.
- `clk_i  in  1`: system clock.
- `rst_n_i  in  1`: asynchronous active-low reset.
- `kb_ready_i  in  1`: one-cycle strobe, scan byte valid.
- `kb_data_i  in  8`: scan byte.
- `sel_i  in  1`: bus access request, held until `ack_o`.
- `we_i  in  1`: 1 means write.
- `addr_i  in  2`: register select.
- `dat_i  in  32`: write data.
- `dat_o  out  32`: read data, valid with `ack_o`.
- `ack_o  out  1`: one-cycle access acknowledge.
- `irq_o  out  1`: interrupt request, level.

## Operation
- Event format, 10 bits: `{ext, brk, code[7:0]}`.
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0). Only a `kb_ready_i` strobe advances it.
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> push `{0,0,b}`, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT; other byte -> push `{1,0,b}`, go to IDLE.
  - BRK: other byte -> push `{0,1,b}`, go to IDLE; E0 or F0 -> IDLE, nothing pushed (malformed).
  - EXT_BRK: other byte -> push `{1,1,b}`, go to IDLE; E0 or F0 -> IDLE, nothing pushed.
- E1, FA and AA are ordinary codes.
- Register map, 32-bit:
  - addr 0 DATA, read only. Bit 31 = FIFO not empty; bits [9:0] = head event, 0 when empty. A read while not empty pops. A read while empty returns 0 and leaves state unchanged.
  - addr 1 STATUS. Bit 0 not empty; bit 1 full; bit 2 overflow (sticky); bits [14:8] count. Write: bit 2 = 1 clears overflow; bit 3 = 1 flushes the FIFO and returns the FSM to IDLE.
  - addr 2 CTRL, read/write. Bit 0 = irq enable. Other bits read 0.
  - addr 3: reads 0, writes ignored.
- Push to a full FIFO: event dropped, overflow set. If a pop lands in the same cycle, the pop happens first and the push is accepted. Overflow stays clear.
- Flush in the same cycle as a push: the flush wins, and the FIFO is left empty.
- Count wraps modulo 2·`DEPTH` internally. Full means count == `DEPTH`.
- Reset values: `dat_o` = 0, `ack_o` = 0, `irq_o` = 0, FSM = IDLE, FIFO empty, overflow = 0, irq enable = 0. Reset in the middle of a prefix sequence discards the partial event.

## Timing
- Push: the event is in the FIFO on the clock edge after the strobe on which the final code byte arrives. STATUS shows it one cycle after that strobe.
- Bus access: `ack_o` and registered `dat_o` assert the cycle after `sel_i` rises, for exactly one cycle. The pop or write takes effect on that same edge.
- `sel_i` still high after `ack_o`: treated as a new access; a back-to-back read pops again. Masters deassert `sel_i` after `ack_o`.
- No backpressure toward the receiver; `kb_ready_i` is always accepted.

## Configuration
- `KB_CTRL_IRQ_EN` defined: `irq_o` = irq enable AND (not empty OR overflow), registered, so it lags by one cycle.
- Undefined: `irq_o` tied to 0. CTRL bit 0 still reads and writes but has no effect.

## Structure
- Package `kb_pkg` holds:
  - prefix constants `KB_PFX_EXT` = 8'hE0 and `KB_PFX_BRK` = 8'hF0;
  - the FSM state enum;
  - register address constants;
  - the 10-bit event typedef.
- Sub-module `kb_fifo`: synchronous FIFO, parameter `DEPTH`, with push/pop/flush, full/empty/count. Same-cycle push and pop are legal.

## Test plan
- Bytes 1C, then F0 1C -> DATA reads 0x8000001C, then 0x8000011C; third read returns 0.
- Bytes E0 75, then E0 F0 75 -> reads 0x80000275, then 0x80000375.
- F0 E0 1C (malformed) -> nothing pushed for F0 E0; then 1C is pushed as 0x1C.
- 9 codes with `DEPTH` = 8 -> STATUS full = 1, overflow = 1, count = 8. Write STATUS bit 2 -> overflow = 0. 8 reads drain the codes in order.
- Full FIFO, with a DATA read and a strobe in the same cycle -> count stays 8, no overflow, new code is last out.
- With the macro defined, CTRL = 1 and one code pushed -> `irq_o` high 2 cycles after the strobe, low 1 cycle after the draining read. `rst_n_i` pulled low after E0 -> all outputs 0 immediately; the next byte 75 yields 0x75.

Source files
------------

// File: rtl/kb_pkg.sv
// kb_pkg: shared constants, prefix-FSM states and the key-event type for kb_ctrl.
package kb_pkg;

  localparam logic [7:0] KB_PFX_EXT = 8'hE0;
  localparam logic [7:0] KB_PFX_BRK = 8'hF0;

  localparam logic [1:0] KB_ADDR_DATA   = 2'd0;
  localparam logic [1:0] KB_ADDR_STATUS = 2'd1;
  localparam logic [1:0] KB_ADDR_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    KB_IDLE,
    KB_EXT,
    KB_BRK,
    KB_EXT_BRK
  } kb_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == KB_PFX_EXT) || (b == KB_PFX_BRK);
  endfunction

endpackage

// File: rtl/kb_ctrl_if.sv
// kb_ctrl_if: CPU-side register bus of the keyboard controller, plus its interrupt line.
interface kb_ctrl_if;

  logic        sel_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        irq_o;

  modport master (output sel_i, we_i, addr_i, dat_i, input dat_o, ack_o, irq_o);
  modport slave  (input sel_i, we_i, addr_i, dat_i, output dat_o, ack_o, irq_o);

endinterface

// File: rtl/kb_fifo.sv
// kb_fifo: synchronous key-event FIFO with push/pop/flush; pointers carry an extra wrap bit.
module kb_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push,
  input  kb_event_t                  wr_data,
  input  logic                       pop,
  input  logic                       flush,
  output kb_event_t                  rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  kb_event_t   mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  // A pop frees the slot first, so a push into a full FIFO still lands when both occur together.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/kb_ctrl.sv
// kb_ctrl: folds E0/F0 prefixes into key events, queues them and serves DATA/STATUS/CTRL registers.
// Define KB_CTRL_IRQ_EN to drive irq_o from CTRL enable; otherwise irq_o is tied low.
module kb_ctrl
  import kb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       kb_ready_i,
  input  logic [7:0] kb_data_i,
  kb_ctrl_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  kb_state_e   state_q, state_d;
  logic        push;
  kb_event_t   push_evt;
  logic        access, rd_acc, wr_acc;
  logic        pop, flush, ovf_clr, drop;
  logic        full, empty;
  logic [AW:0] count;
  kb_event_t   head;
  logic        overflow_q, irq_en_q;
  logic [31:0] rdata;
  logic        unused_dat;

  assign unused_dat = ^{bus.dat_i[31:4], bus.dat_i[1]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   state_q <= KB_IDLE;
    else if (flush) state_q <= KB_IDLE;
    else            state_q <= state_d;
  end

  // A prefix after F0 is malformed and abandons the partial event.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_evt = '0;
    if (kb_ready_i) begin
      unique case (state_q)
        KB_IDLE: begin
          if (kb_data_i == KB_PFX_EXT)      state_d = KB_EXT;
          else if (kb_data_i == KB_PFX_BRK) state_d = KB_BRK;
          else begin
            push     = 1'b1;
            push_evt = '{ext: 1'b0, brk: 1'b0, code: kb_data_i};
          end
        end
        KB_EXT: begin
          if (kb_data_i == KB_PFX_BRK)      state_d = KB_EXT_BRK;
          else if (kb_data_i == KB_PFX_EXT) state_d = KB_EXT;
          else begin
            state_d  = KB_IDLE;
            push     = 1'b1;
            push_evt = '{ext: 1'b1, brk: 1'b0, code: kb_data_i};
          end
        end
        KB_BRK: begin
          state_d  = KB_IDLE;
          push     = !is_prefix(kb_data_i);
          push_evt = '{ext: 1'b0, brk: 1'b1, code: kb_data_i};
        end
        KB_EXT_BRK: begin
          state_d  = KB_IDLE;
          push     = !is_prefix(kb_data_i);
          push_evt = '{ext: 1'b1, brk: 1'b1, code: kb_data_i};
        end
      endcase
    end
  end

  kb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .wr_data (push_evt),
    .pop     (pop),
    .flush   (flush),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // A held sel_i re-arms on the cycle after ack, so each ack marks exactly one access.
  assign access  = bus.sel_i && !bus.ack_o;
  assign rd_acc  = access && !bus.we_i;
  assign wr_acc  = access && bus.we_i;
  assign pop     = rd_acc && (bus.addr_i == KB_ADDR_DATA) && !empty;
  assign flush   = wr_acc && (bus.addr_i == KB_ADDR_STATUS) && bus.dat_i[3];
  assign ovf_clr = wr_acc && (bus.addr_i == KB_ADDR_STATUS) && bus.dat_i[2];
  assign drop    = push && full && !pop && !flush;

  always_comb begin
    rdata = '0;
    case (bus.addr_i)
      KB_ADDR_DATA: begin
        if (!empty) begin
          rdata[31]  = 1'b1;
          rdata[9:0] = head;
        end
      end
      KB_ADDR_STATUS: begin
        rdata[0]          = !empty;
        rdata[1]          = full;
        rdata[2]          = overflow_q;
        rdata[8 +: AW+1]  = count;
      end
      KB_ADDR_CTRL: rdata[0] = irq_en_q;
      default: rdata = '0;
    endcase
  end

  // A fresh drop outranks a same-cycle overflow clear so no lost event goes unreported.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.ack_o  <= 1'b0;
      bus.dat_o  <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      bus.ack_o <= access;
      bus.dat_o <= rd_acc ? rdata : '0;
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
      if (wr_acc && (bus.addr_i == KB_ADDR_CTRL)) irq_en_q <= bus.dat_i[0];
    end
  end

`ifdef KB_CTRL_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= irq_en_q && (!empty || overflow_q);
  end

  assign bus.irq_o = irq_q;
`else
  assign bus.irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_kb_ctrl.sv
// tb_kb_ctrl: directed literal checks plus randomized traffic compared each cycle against a queue model.
module tb_kb_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kb_ready = 1'b0;
  logic [7:0] kb_data = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  kb_ctrl_if bus ();

  kb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .kb_ready_i (kb_ready),
    .kb_data_i  (kb_data),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending-prefix flags and a plain event queue, stepped once per clock edge.
  logic [9:0]  q [$];
  bit          m_ext, m_brk, m_ov, m_en;
  logic        m_ack, m_irq;
  logic [31:0] m_dat;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] rd;
    logic [9:0]  ev;
    bit          acc, pop, flush, clr, have, irq_n;
    if (!rst_n) begin
      q.delete();
      m_ext = 0; m_brk = 0; m_ov = 0; m_en = 0;
      m_ack = 0; m_irq = 0; m_dat = '0;
    end else begin
`ifdef KB_CTRL_IRQ_EN
      irq_n = m_en && (q.size() != 0 || m_ov);
`else
      irq_n = 0;
`endif
      acc = bus.sel_i && !m_ack;
      rd = '0; pop = 0; flush = 0; clr = 0; have = 0; ev = '0;
      if (acc && !bus.we_i) begin
        case (bus.addr_i)
          2'd0: if (q.size() != 0) begin rd = 32'h8000_0000 | 32'(q[0]); pop = 1; end
          2'd1: rd = (32'(q.size()) << 8) | (32'(m_ov) << 2)
                     | (32'(q.size() == DEPTH) << 1) | 32'(q.size() != 0);
          2'd2: rd = 32'(m_en);
          default: rd = '0;
        endcase
      end
      if (acc && bus.we_i) begin
        if (bus.addr_i == 2'd1) begin clr = bus.dat_i[2]; flush = bus.dat_i[3]; end
        if (bus.addr_i == 2'd2) m_en = bus.dat_i[0];
      end
      if (kb_ready) begin
        if (kb_data == 8'hE0 || kb_data == 8'hF0) begin
          if (m_brk) begin m_ext = 0; m_brk = 0; end
          else if (kb_data == 8'hF0) m_brk = 1;
          else m_ext = 1;
        end else begin
          have = 1; ev = {m_ext, m_brk, kb_data};
          m_ext = 0; m_brk = 0;
        end
      end
      if (clr) m_ov = 0;
      if (flush) begin
        q.delete(); m_ext = 0; m_brk = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (have) begin
          if (q.size() < DEPTH) q.push_back(ev);
          else m_ov = 1;
        end
      end
      m_ack = acc; m_dat = rd; m_irq = irq_n;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_ack", 32'(bus.ack_o), 32'(m_ack));
      if (m_ack) checkOutput("model_dat", bus.dat_o, m_dat);
      checkOutput("model_irq", 32'(bus.irq_o), 32'(m_irq));
    end
  end

  task automatic busAccess(input bit we, input logic [1:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    int waited = 0;
    @(negedge clk);
    bus.sel_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.dat_i = wdata;
    do begin
      @(posedge clk); #1; waited++;
    end while (!bus.ack_o && waited < 8);
    if (!bus.ack_o) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL ack_timeout: no ack after %0d cycles, expected ack", waited);
    end
    rdata = bus.dat_o;
    @(negedge clk);
    bus.sel_i = 1'b0; bus.we_i = 1'b0;
  endtask

  task automatic readExpect(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    busAccess(1'b0, addr, '0, r);
    checkOutput(name, r, exp);
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] val);
    logic [31:0] r;
    busAccess(1'b1, addr, val, r);
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk); kb_ready = 1'b1; kb_data = b;
    @(negedge clk); kb_ready = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      kb_ready = ($urandom_range(0, 99) < 35);
      case ($urandom_range(0, 7))
        0: kb_data = 8'hE0;
        1: kb_data = 8'hF0;
        2: kb_data = 8'hE1;
        3: kb_data = 8'hFA;
        4: kb_data = 8'hAA;
        default: kb_data = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 99) < 30) begin
        bus.sel_i  = 1'b1;
        bus.we_i   = ($urandom_range(0, 3) == 0);
        bus.addr_i = 2'($urandom_range(0, 3));
        bus.dat_i  = $urandom;
        if ($urandom_range(0, 7) != 0) bus.dat_i[3] = 1'b0;
      end else begin
        bus.sel_i = 1'b0;
      end
    end
    @(negedge clk);
    kb_ready = 1'b0; bus.sel_i = 1'b0; bus.we_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit irq_on;
`ifdef KB_CTRL_IRQ_EN
    irq_on = 1;
`else
    irq_on = 0;
`endif
    bus.sel_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 2'd0; bus.dat_i = '0;
    #1;
    checkOutput("reset_ack", 32'(bus.ack_o), 32'd0);
    checkOutput("reset_dat", bus.dat_o, 32'd0);
    checkOutput("reset_irq", 32'(bus.irq_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    readExpect("status_after_reset", 2'd1, 32'h0);
    sendByte(8'h1C); sendByte(8'hF0); sendByte(8'h1C);
    readExpect("make_1c",  2'd0, 32'h8000_001C);
    readExpect("break_1c", 2'd0, 32'h8000_011C);
    readExpect("empty_read", 2'd0, 32'h0);

    sendByte(8'hE0); sendByte(8'h75);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
    readExpect("ext_make_75",  2'd0, 32'h8000_0275);
    readExpect("ext_break_75", 2'd0, 32'h8000_0375);

    sendByte(8'hF0); sendByte(8'hE0); sendByte(8'h1C);
    readExpect("malformed_then_1c", 2'd0, 32'h8000_001C);
    readExpect("malformed_nothing_else", 2'd0, 32'h0);

    for (int i = 0; i < 9; i++) sendByte(8'h10 + 8'(i));
    readExpect("status_overflow", 2'd1, 32'h0000_0807);
    writeReg(2'd1, 32'h4);
    readExpect("status_ovf_cleared", 2'd1, 32'h0000_0803);
    for (int i = 0; i < 8; i++) readExpect("drain_order", 2'd0, 32'h8000_0010 + 32'(i));
    readExpect("status_drained", 2'd1, 32'h0);

    for (int i = 0; i < 8; i++) sendByte(8'h20 + 8'(i));
    @(negedge clk);
    bus.sel_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 2'd0;
    kb_ready = 1'b1; kb_data = 8'h30;
    @(posedge clk); #1;
    checkOutput("pop_push_ack", 32'(bus.ack_o), 32'd1);
    checkOutput("pop_push_dat", bus.dat_o, 32'h8000_0020);
    @(negedge clk);
    bus.sel_i = 1'b0; kb_ready = 1'b0;
    readExpect("status_pop_push", 2'd1, 32'h0000_0803);
    for (int i = 1; i < 8; i++) readExpect("pop_push_drain", 2'd0, 32'h8000_0020 + 32'(i));
    readExpect("pop_push_last", 2'd0, 32'h8000_0030);

    sendByte(8'h11); sendByte(8'h22); sendByte(8'hE0);
    writeReg(2'd1, 32'h8);
    readExpect("status_flushed", 2'd1, 32'h0);
    sendByte(8'h1C);
    readExpect("after_flush_idle", 2'd0, 32'h8000_001C);

    writeReg(2'd2, 32'hFFFF_FFFF);
    readExpect("ctrl_readback", 2'd2, 32'h1);
    @(negedge clk); kb_ready = 1'b1; kb_data = 8'h5A;
    @(negedge clk); kb_ready = 1'b0;
    checkOutput("irq_lag", 32'(bus.irq_o), 32'd0);
    @(posedge clk); #1;
    checkOutput("irq_rise", 32'(bus.irq_o), 32'(irq_on));
    readExpect("irq_event", 2'd0, 32'h8000_005A);
    checkOutput("irq_hold", 32'(bus.irq_o), 32'(irq_on));
    @(posedge clk); #1;
    checkOutput("irq_fall", 32'(bus.irq_o), 32'd0);

    sendByte(8'hE0);
    @(negedge clk);
    bus.sel_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 2'd2;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ack", 32'(bus.ack_o), 32'd0);
    checkOutput("async_rst_dat", bus.dat_o, 32'd0);
    checkOutput("async_rst_irq", 32'(bus.irq_o), 32'd0);
    bus.sel_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    readExpect("ctrl_after_reset", 2'd2, 32'h0);
    sendByte(8'h75);
    readExpect("prefix_discarded", 2'd0, 32'h8000_0075);

    applyStimulus(3000);
    writeReg(2'd2, 32'h1);
    applyStimulus(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
